// File: rtl/dsp_file_server.sv
`default_nettype none
// ============================================================================
// Module      : dsp_file_server
// Description : Responder for the DSP equation file interface. Holds
//               NUM_FILES word-wide files in one flat RAM, each with its own
//               read and write pointer, and services read, write and seek
//               requests behind a file_active busy handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_file_server #(
  parameter int dw        = 32,
  parameter int NUM_FILES = 4,
  parameter int FILE_AW   = 8
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic [7:0]    file_num,
  input  logic          file_read,
  input  logic          file_write,
  input  logic          file_reset,
  input  logic [31:0]   file_rd_ptr_offset,
  input  logic [dw-1:0] file_write_data,
  output logic [dw-1:0] file_read_data,
  output logic          file_active,
  output logic [31:0]   rd_ptr,
  output logic [31:0]   wr_ptr,
  output logic          error
);

  localparam int FILE_DEPTH = 1 << FILE_AW;
  localparam int PW         = FILE_AW + 1;                              // pointer width, holds 0..FILE_DEPTH
  localparam int FW         = (NUM_FILES > 1) ? $clog2(NUM_FILES) : 1;  // file index width
  localparam int AW         = FW + FILE_AW;                             // flat RAM address width
  localparam logic [PW-1:0] FULL_PTR = PW'(FILE_DEPTH);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_ADDR = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR      = 3'd3;
  localparam logic [2:0] S_SEEK    = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [FW-1:0] fnum_q, fnum_d;
  logic [dw-1:0] wdata_q, wdata_d;
  logic [31:0]   offset_q, offset_d;
  logic          error_q, error_d;
  logic [dw-1:0] rdata_q;
  logic [dw-1:0] ram_q;
  logic [PW-1:0] rd_ptr_q [NUM_FILES];
  logic [PW-1:0] wr_ptr_q [NUM_FILES];
  logic [dw-1:0] mem [0:(1 << AW)-1];

  logic          num_ok;
  logic [FW-1:0] req_idx;
  logic [PW-1:0] req_rd, req_wr;
  logic [1:0]    req_cnt;
  logic [PW-1:0] cur_rd, cur_wr, seek_ptr;

  // Decode of the incoming request against the addressed file's pointers
  always_comb begin
    num_ok  = ({24'd0, file_num} < 32'(NUM_FILES));
    req_idx = file_num[FW-1:0];
    req_rd  = num_ok ? rd_ptr_q[req_idx] : '0;
    req_wr  = num_ok ? wr_ptr_q[req_idx] : '0;
    req_cnt = {1'b0, file_read} + {1'b0, file_write} + {1'b0, file_reset};
  end

  // Pointers of the file latched for the operation in flight; seek target clamped to wr_ptr
  always_comb begin
    cur_rd   = rd_ptr_q[fnum_q];
    cur_wr   = wr_ptr_q[fnum_q];
    seek_ptr = (offset_q > 32'(cur_wr)) ? cur_wr : offset_q[PW-1:0];
  end

  // Next-state logic: requests are validated and latched only in IDLE
  always_comb begin
    state_d  = state_q;
    error_d  = 1'b0;
    fnum_d   = fnum_q;
    wdata_d  = wdata_q;
    offset_d = offset_q;
    case (state_q)
      S_IDLE: begin
        if (req_cnt != 2'd0) begin
          if (req_cnt != 2'd1 || !num_ok) begin
            error_d = 1'b1;
          end else if (file_read) begin
            if (req_rd == req_wr) begin
              error_d = 1'b1;
            end else begin
              state_d = S_RD_ADDR;
              fnum_d  = req_idx;
            end
          end else if (file_write) begin
            if (req_wr == FULL_PTR) begin
              error_d = 1'b1;
            end else begin
              state_d = S_WR;
              fnum_d  = req_idx;
              wdata_d = file_write_data;
            end
          end else begin
            // Seek beyond the written data is still performed (clamped) but flagged
            state_d  = S_SEEK;
            fnum_d   = req_idx;
            offset_d = file_rd_ptr_offset;
            error_d  = (file_rd_ptr_offset > 32'(req_wr));
          end
        end
      end
      S_RD_ADDR: state_d = S_RD_DATA;
      S_RD_DATA: state_d = S_IDLE;
      S_WR:      state_d = S_IDLE;
      S_SEEK:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Control registers: FSM state, latched request fields and the error pulse
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q  <= S_IDLE;
      fnum_q   <= '0;
      wdata_q  <= '0;
      offset_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      fnum_q   <= fnum_d;
      wdata_q  <= wdata_d;
      offset_q <= offset_d;
      error_q  <= error_d;
    end
  end

  // Per-file pointers and the read-data holding register
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      for (int i = 0; i < NUM_FILES; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      case (state_q)
        S_RD_DATA: begin
          rdata_q          <= ram_q;
          rd_ptr_q[fnum_q] <= cur_rd + 1'b1;
        end
        S_WR:    wr_ptr_q[fnum_q] <= cur_wr + 1'b1;
        S_SEEK:  rd_ptr_q[fnum_q] <= seek_ptr;
        default: ;
      endcase
    end
  end

  // File RAM: contents survive reset, read is registered one cycle ahead of RD_DATA
  always_ff @(posedge wb_clk) begin
    if (state_q == S_WR) begin
      mem[{fnum_q, cur_wr[FILE_AW-1:0]}] <= wdata_q;
    end
    if (state_q == S_RD_ADDR) begin
      ram_q <= mem[{fnum_q, cur_rd[FILE_AW-1:0]}];
    end
  end

  assign file_read_data = rdata_q;
  assign file_active    = (state_q != S_IDLE);
  assign error          = error_q;
  assign rd_ptr         = 32'(req_rd);
  assign wr_ptr         = 32'(req_wr);

endmodule
`default_nettype wire
